// File: rtl/cic_comp_pkg.sv
// Shared parameters, compensation taps and FSM encoding for the CIC droop-compensation FIR.
// The taps are symmetric and sum to 2**COEF_FRAC, which gives unity DC gain.
package cic_comp_pkg;

  localparam int NUM_TAPS    = 16;
  localparam int COEF_WIDTH  = 16;
  localparam int COEF_FRAC   = 15;
  localparam int ACC_WIDTH   = 40;
  localparam int DECIMATE    = 2;
  localparam int DATA_WIDTH  = 12;
  localparam int PROD_WIDTH  = DATA_WIDTH + COEF_WIDTH;
  localparam int PTR_WIDTH   = $clog2(NUM_TAPS);
  localparam int PHASE_WIDTH = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  localparam logic signed [ACC_WIDTH-1:0] RND_BIAS = ACC_WIDTH'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [ACC_WIDTH-1:0] Y_MAX    = ACC_WIDTH'(2047);
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN    = -ACC_WIDTH'(2048);

  // Alternating outer taps against a large centre pair lift the CIC passband edge.
  localparam logic signed [COEF_WIDTH-1:0] COEF [NUM_TAPS] = '{
    -16'sd120,  16'sd180, -16'sd400,  16'sd700, -16'sd1200, 16'sd2200, 16'sd5000, 16'sd10024,
     16'sd10024, 16'sd5000, 16'sd2200, -16'sd1200, 16'sd700, -16'sd400, 16'sd180, -16'sd120
  };

  typedef enum logic [1:0] {CLR, IDLE, MAC, RND} comp_state_t;

endpackage

// File: rtl/cic_comp_ring_buf.sv
// NUM_TAPS x 12 sample history with one write port and one combinational read port.
// Read address is relative to the newest sample: rd_k=0 returns the last value written.
module cic_comp_ring_buf
  import cic_comp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic [PTR_WIDTH-1:0]  rd_k,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  logic [DATA_WIDTH-1:0] mem [NUM_TAPS];
  logic [PTR_WIDTH-1:0]  wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PTR_WIDTH'(1);
    end
  end

  // Storage is zeroed by the CLR sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  assign rd_dat = mem[wr_ptr - PTR_WIDTH'(1) - rd_k];

endmodule

// File: rtl/cic_comp_fir.sv
// Decimate-by-2 CIC compensation FIR with a single time-multiplexed MAC; output NUM_TAPS+2 clk after the strobe.
// Define CIC_COMP_SAT_EN to clamp the output to 12 bits and add the sat flag port.
module cic_comp_fir
  import cic_comp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  d_clk,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  d_out_valid,
  output logic                  overrun
`ifdef CIC_COMP_SAT_EN
  ,
  output logic                  sat
`endif
);

  comp_state_t                  state, state_nxt;
  logic                         d_clk_q, sample_stb, accept, busy_hit;
  logic                         last_phase, last_cnt;
  logic                         clr_wr, mac_en, rnd_en;
  logic [PTR_WIDTH-1:0]         cnt;
  logic [PHASE_WIDTH-1:0]       phase;
  logic [DATA_WIDTH-1:0]        wr_dat, rd_dat, y_out;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc, acc_rnd;
  logic                         sat_hit;

  assign sample_stb = d_clk & ~d_clk_q;
  assign accept     = sample_stb & (state == IDLE);
  assign busy_hit   = sample_stb & (state != IDLE);
  assign last_phase = (phase == PHASE_WIDTH'(DECIMATE - 1));
  assign last_cnt   = (cnt == PTR_WIDTH'(NUM_TAPS - 1));
  assign wr_dat     = clr_wr ? '0 : d_in;

  cic_comp_ring_buf u_ring (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (clr_wr | accept),
    .wr_dat (wr_dat),
    .rd_k   (cnt),
    .rd_dat (rd_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLR:     if (last_cnt) state_nxt = IDLE;
      IDLE:    if (accept && last_phase) state_nxt = MAC;
      MAC:     if (last_cnt) state_nxt = RND;
      RND:     state_nxt = IDLE;
      default: state_nxt = CLR;
    endcase
  end

  always_comb begin
    clr_wr = (state == CLR);
    mac_en = (state == MAC);
    rnd_en = (state == RND);
  end

  assign prod    = $signed(rd_dat) * COEF[cnt];
  assign acc_rnd = acc + RND_BIAS;

`ifdef CIC_COMP_SAT_EN
  always_comb begin
    sat_hit = 1'b0;
    y_out   = DATA_WIDTH'(acc_rnd >>> COEF_FRAC);
    if ((acc_rnd >>> COEF_FRAC) > Y_MAX) begin
      sat_hit = 1'b1;
      y_out   = Y_MAX[DATA_WIDTH-1:0];
    end else if ((acc_rnd >>> COEF_FRAC) < Y_MIN) begin
      sat_hit = 1'b1;
      y_out   = Y_MIN[DATA_WIDTH-1:0];
    end
  end
`else
  assign sat_hit = 1'b0;
  assign y_out   = DATA_WIDTH'(acc_rnd >>> COEF_FRAC);
`endif

  // cnt walks the CLR sweep and the MAC taps, wrapping to 0 at the end of each.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_clk_q <= 1'b0;
      cnt     <= '0;
      phase   <= '0;
      acc     <= '0;
    end else begin
      d_clk_q <= d_clk;
      cnt     <= (clr_wr | mac_en) ? cnt + PTR_WIDTH'(1) : '0;
      if (accept) begin
        phase <= last_phase ? '0 : phase + PHASE_WIDTH'(1);
        acc   <= '0;
      end else if (mac_en) begin
        acc <= acc + ACC_WIDTH'(prod);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out       <= '0;
      d_out_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      d_out_valid <= rnd_en;
      if (rnd_en) begin
        d_out <= y_out;
      end
      if (busy_hit) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef CIC_COMP_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat <= 1'b0;
    end else begin
      sat <= rnd_en & sat_hit;
    end
  end
`endif

endmodule

// File: tb/tb_cic_comp_fir.sv
// Randomised scoreboard bench for cic_comp_fir against a sample-history reference model.
module tb_cic_comp_fir;
  import cic_comp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_clk;
  logic [11:0] d_in;
  logic [11:0] d_out;
  logic        d_out_valid;
  logic        overrun;
`ifdef CIC_COMP_SAT_EN
  logic        sat;
`endif

  cic_comp_fir dut (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .d_clk       (d_clk),
    .d_out       (d_out),
    .d_out_valid (d_out_valid),
    .overrun     (overrun)
`ifdef CIC_COMP_SAT_EN
    ,
    .sat         (sat)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int dout;
    int sat;
    int at;
  } exp_t;
  exp_t q[$];

  // Reference model: accepted-sample history, decimation phase, first cycle the filter is free.
  int hist[$];
  int phase_m   = 0;
  int next_free = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    q.delete();
    phase_m   = 0;
    next_free = 0;
  endfunction

  function automatic void model_accept(input int v, input int edge_cyc);
    longint acc;
    longint y;
    exp_t   e;
    if (edge_cyc < next_free) return;
    hist.push_back(v);
    if (hist.size() > NUM_TAPS) void'(hist.pop_front());
    if (phase_m != DECIMATE - 1) begin
      phase_m++;
      return;
    end
    phase_m = 0;
    acc = 0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      int idx;
      idx = hist.size() - 1 - k;
      if (idx >= 0) acc += longint'(COEF[k]) * longint'(hist[idx]);
    end
    y = (acc + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC;
`ifdef CIC_COMP_SAT_EN
    e.sat  = (y > 2047 || y < -2048) ? 1 : 0;
    e.dout = (y > 2047) ? 2047 : (y < -2048) ? -2048 : int'(y);
`else
    e.sat  = 0;
    y      = y & 64'hfff;
    e.dout = (y >= 2048) ? int'(y - 4096) : int'(y);
`endif
    e.at = edge_cyc + NUM_TAPS + 1;
    q.push_back(e);
    next_free = edge_cyc + NUM_TAPS + 2;
  endfunction

  task automatic strobe(input int v, input int spacing);
    int h;
    h = spacing / 2;
    @(posedge clk);
    #1;
    d_in  = v[11:0];
    d_clk = 1'b1;
    model_accept(v, cyc + 1);
    repeat (h) @(posedge clk);
    #1 d_clk = 1'b0;
    repeat (spacing - h - 1) @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_queue_empty", q.size(), 0);
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  always @(negedge clk) begin
    if (!rst && d_out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("d_out", int'($signed(d_out)), e.dout);
        check("valid_cycle", cyc, e.at);
`ifdef CIC_COMP_SAT_EN
        check("sat", int'(sat), e.sat);
`endif
      end
    end
  end

  initial begin
    int vcount;
    rst   = 1'b1;
    d_clk = 1'b0;
    d_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_d_out", int'(d_out), 0);
    check("reset_valid", int'(d_out_valid), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);

    // Impulse: odd taps appear in turn, then zeros.
    strobe(2047, 32);
    for (int i = 0; i < 19; i++) strobe(0, 32);
    drain();

    // DC: unity gain once the history is full.
    for (int i = 0; i < 24; i++) strobe(1000, 20);
    drain();
    check("dc_settled", int'($signed(d_out)), 1000);

    // Random samples at legal spacing, including the minimum of NUM_TAPS+2.
    for (int i = 0; i < 30; i++) strobe(rand_sample(), int'($urandom_range(NUM_TAPS + 2, 30)));
    drain();
    check("no_overrun_yet", int'(overrun), 0);

    // Overrun: strobes too close together are dropped and the flag sticks.
    for (int i = 0; i < 8; i++) strobe(rand_sample(), 10);
    for (int i = 0; i < 6; i++) strobe(rand_sample(), 20);
    drain();
    check("overrun_sticky", int'(overrun), 1);

    // Reset in the middle of MAC: no output and async clear.
    if (phase_m != DECIMATE - 1) strobe(rand_sample(), 20);
    @(posedge clk);
    #1;
    d_in  = 12'd500;
    d_clk = 1'b1;
    model_accept(500, cyc + 1);
    repeat (8) @(posedge clk);
    #1;
    rst   = 1'b1;
    d_clk = 1'b0;
    model_reset();
    #1;
    check("async_rst_d_out", int'(d_out), 0);
    check("async_rst_valid", int'(d_out_valid), 0);
    check("async_rst_overrun", int'(overrun), 0);
    vcount = 0;
    repeat (2) begin
      @(negedge clk);
      if (d_out_valid) vcount++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (d_out_valid) vcount++;
    end
    check("no_valid_after_abort", vcount, 0);

    // Sign-matched input drives the peak gain above 1; earlier outputs prove the ring was cleared.
    for (int m = 0; m < NUM_TAPS; m++) strobe((COEF[m] < 0) ? -2047 : 2047, 20);
    drain();
`ifdef CIC_COMP_SAT_EN
    check("sat_peak", int'($signed(d_out)), 2047);
`else
    check("wrap_peak", int'($signed(d_out)), -1619);
`endif

    repeat (5) @(posedge clk);
    check("final_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
